// File: rtl/vending_pkg.sv
// -----------------------------------------------------------------------------
// vending_pkg
// Shared definitions for the vending machine datapath: the 2-bit coin code
// driven from the coin acceptor into the vending FSM, and a channel identifier
// used by the acceptor's arbiter.
// -----------------------------------------------------------------------------
package vending_pkg;

    localparam int COIN_W = 2;

    localparam logic [COIN_W-1:0] COIN_NONE = 2'b00;
    localparam logic [COIN_W-1:0] COIN_HALF = 2'b01;
    localparam logic [COIN_W-1:0] COIN_ONE  = 2'b10;

    // Coin slot channels; the value doubles as the channel index.
    typedef enum logic {
        CH_HALF = 1'b0,
        CH_ONE  = 1'b1
    } chan_e;

    // Coin code emitted when a given channel is granted.
    function automatic logic [COIN_W-1:0] chan_code(input chan_e ch);
        return (ch == CH_ONE) ? COIN_ONE : COIN_HALF;
    endfunction

endpackage

// File: rtl/coin_debounce.sv
// -----------------------------------------------------------------------------
// coin_debounce
// One coin-slot sensor front end: 2-flop synchronizer, stability-count
// debouncer and rising-edge detector.
//
// Ports:
//   clk     system clock
//   rstn    asynchronous active-low reset
//   raw_i   raw, asynchronous, bouncy sensor level (high = coin present)
//   rise_o  one-cycle pulse on each accepted 0 -> 1 debounced transition
//
// Parameter DEBOUNCE_CYC: consecutive synchronized samples that must disagree
// with the current debounced level before the level is allowed to change.
// -----------------------------------------------------------------------------
module coin_debounce #(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic raw_i,
    output logic rise_o
);

    localparam int              CW       = $clog2(DEBOUNCE_CYC);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          deb_q;
    logic          deb_prev_q;
    logic [CW-1:0] cnt_q;

    // Everything resets high so a sensor held high across reset release is
    // treated as "already present" and never yields a coin.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            deb_q      <= 1'b1;
            deb_prev_q <= 1'b1;
            cnt_q      <= '0;
        end else begin
            sync1_q    <= raw_i;
            sync2_q    <= sync1_q;
            deb_prev_q <= deb_q;
            if (sync2_q == deb_q) begin
                // Any agreeing sample restarts the stability run.
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                deb_q <= sync2_q;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign rise_o = deb_q & ~deb_prev_q;

endmodule

// File: rtl/coin_acceptor.sv
// -----------------------------------------------------------------------------
// coin_acceptor
// Front end of the vending machine: turns the two raw slot sensors into clean
// one-cycle coin codes for the vending FSM. Each channel keeps a small count of
// coins waiting for the FSM; a fair arbiter serializes them one per cycle while
// accept_en is high, and a coin arriving on a full channel is returned.
//
// Ports:
//   clk            system clock
//   rstn           asynchronous active-low reset
//   coin_half_raw  raw 0.5-slot sensor (async, bouncy, high = coin present)
//   coin_one_raw   raw 1-slot sensor (same properties)
//   accept_en      downstream FSM ready; coins are emitted only while high
//   coin           registered coin code: 00 none, 01 = 0.5, 10 = 1
//   coin_reject    one-cycle pulse when a coin arrived on a full channel
//   busy           high while any coin is queued
// -----------------------------------------------------------------------------
module coin_acceptor
    import vending_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 4,
    parameter int PEND_MAX     = 3
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              coin_half_raw,
    input  logic              coin_one_raw,
    input  logic              accept_en,
    output logic [COIN_W-1:0] coin,
    output logic              coin_reject,
    output logic              busy
);

    localparam logic [1:0] PEND_LIM = 2'(PEND_MAX);

    // Channel vectors are indexed by chan_e: bit 0 = 0.5 slot, bit 1 = 1 slot.
    logic [1:0] raw_w;
    logic [1:0] ev_w;       // debounced rising edge per channel
    logic [1:0] pend_nz_w;  // channel has at least one queued coin
    logic [1:0] ovf_w;      // coin arrived on a full channel this cycle
    logic [1:0] gnt;        // one-hot grant, or zero

    chan_e              last_grant_q, last_grant_d;
    logic [COIN_W-1:0]  coin_q, coin_d;
    logic               coin_reject_q, coin_reject_d;

    assign raw_w = {coin_one_raw, coin_half_raw};

    // Per-channel front end and pending counter.
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
        logic [1:0] pend_q, pend_d;
        logic       ovf;

        coin_debounce #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC)
        ) u_debounce (
            .clk    (clk),
            .rstn   (rstn),
            .raw_i  (raw_w[gi]),
            .rise_o (ev_w[gi])
        );

        // A coin that arrives in the same cycle one is granted leaves the
        // count unchanged; it effectively takes the departing coin's slot.
        always_comb begin
            pend_d = pend_q;
            ovf    = 1'b0;
            if (ev_w[gi] && !gnt[gi]) begin
                if (pend_q == PEND_LIM) begin
                    ovf = 1'b1;
                end else begin
                    pend_d = pend_q + 2'd1;
                end
            end else if (gnt[gi] && !ev_w[gi]) begin
                pend_d = pend_q - 2'd1;
            end
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                pend_q <= '0;
            end else begin
                pend_q <= pend_d;
            end
        end

        assign pend_nz_w[gi] = (pend_q != 2'd0);
        assign ovf_w[gi]     = ovf;
    end

    // Arbiter: round-robin only matters under contention, so last_grant
    // moves only when both channels were pending. A lone channel is granted
    // without disturbing the fairness pointer.
    always_comb begin
        gnt          = 2'b00;
        last_grant_d = last_grant_q;
        if (accept_en) begin
            if (pend_nz_w[CH_HALF] && pend_nz_w[CH_ONE]) begin
                if (last_grant_q == CH_ONE) begin
                    gnt          = 2'b01;
                    last_grant_d = CH_HALF;
                end else begin
                    gnt          = 2'b10;
                    last_grant_d = CH_ONE;
                end
            end else if (pend_nz_w[CH_HALF]) begin
                gnt = 2'b01;
            end else if (pend_nz_w[CH_ONE]) begin
                gnt = 2'b10;
            end
        end
    end

    always_comb begin
        coin_d = COIN_NONE;
        if (gnt[0]) begin
            coin_d = chan_code(CH_HALF);
        end else if (gnt[1]) begin
            coin_d = chan_code(CH_ONE);
        end
    end

    // Simultaneous overflow on both channels still gives a single pulse.
    assign coin_reject_d = |ovf_w;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            coin_q        <= COIN_NONE;
            coin_reject_q <= 1'b0;
            last_grant_q  <= CH_ONE;
        end else begin
            coin_q        <= coin_d;
            coin_reject_q <= coin_reject_d;
            last_grant_q  <= last_grant_d;
        end
    end

    assign coin        = coin_q;
    assign coin_reject = coin_reject_q;
    assign busy        = |pend_nz_w;

endmodule
